// File: rtl/core_status_pkg.sv
// Register map and bit positions for the core status block, shared with harness and firmware headers.
// Offsets are byte offsets within the block; decode looks only at address bits [4:2].
package core_status_pkg;

  localparam logic [7:0] STATUS_OFFS  = 8'h00;
  localparam logic [7:0] SCRATCH_OFFS = 8'h04;
  localparam logic [7:0] PUSH_OFFS    = 8'h08;
  localparam logic [7:0] POP_OFFS     = 8'h0C;
  localparam logic [7:0] FSTAT_OFFS   = 8'h10;
  localparam logic [7:0] CYCLES_OFFS  = 8'h14;

  localparam int unsigned STATUS_DONE_BIT = 31;
  localparam int unsigned POP_VALID_BIT   = 31;
  localparam int unsigned FSTAT_OVF_BIT   = 31;
  localparam int unsigned FSTAT_FULL_BIT  = 16;

  function automatic logic [2:0] reg_idx(input logic [7:0] offs);
    return offs[4:2];
  endfunction

endpackage

// File: rtl/core_status_fifo.sv
// Generic synchronous FIFO: one-cycle push/pop, head visible combinationally.
// Push when full and pop when empty are ignored; the caller owns overflow reporting.
module core_status_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/core_status_apb.sv
// APB3 status/debug-character slave polled by the JTAG harness for end of computation.
// Zero wait states (pready tied high); read data and pslverr are combinational in the access phase.
module core_status_apb
  import core_status_pkg::*;
#(
  parameter int unsigned APB_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [APB_AW-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              eoc_o,
  output logic              char_irq_o
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      status_q, status_d;
  logic [31:0]      scratch_q, scratch_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             eoc_q, eoc_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic             acc_wr, acc_rd;
  logic [2:0]       idx;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [FCW-1:0]   fifo_count;
  logic             unused_addr;

  assign pready      = 1'b1;
  assign acc_wr      = psel & penable & pwrite;
  assign acc_rd      = psel & penable & ~pwrite;
  assign idx         = paddr[4:2];
  assign unused_addr = ^{paddr[APB_AW-1:5], paddr[1:0]};
  assign eoc_o       = eoc_q;
  assign char_irq_o  = irq_q;

  core_status_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk_in),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pwdata[7:0]),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_d  = status_q;
    scratch_d = scratch_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    prdata    = '0;
    pslverr   = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (acc_wr || acc_rd) begin
      case (idx)
        reg_idx(STATUS_OFFS): begin
          prdata = acc_rd ? status_q : '0;
          if (acc_wr) begin
            if (done_q) begin
              pslverr = 1'b1;
            end else begin
              status_d = pwdata;
              done_d   = pwdata[STATUS_DONE_BIT];
            end
          end
        end
        reg_idx(SCRATCH_OFFS): begin
          prdata = acc_rd ? scratch_q : '0;
          if (acc_wr) scratch_d = pwdata;
        end
        reg_idx(PUSH_OFFS): begin
          pslverr = acc_rd | fifo_full;
          if (acc_wr) begin
            fifo_push = ~fifo_full;
            ovf_d     = ovf_q | fifo_full;
          end
        end
        reg_idx(POP_OFFS): begin
          pslverr = acc_wr;
          if (acc_rd && !fifo_empty) begin
            prdata[POP_VALID_BIT] = 1'b1;
            prdata[7:0]           = fifo_head;
            fifo_pop              = 1'b1;
          end
        end
        reg_idx(FSTAT_OFFS): begin
          if (acc_rd) begin
            prdata[FSTAT_OVF_BIT]  = ovf_q;
            prdata[FSTAT_FULL_BIT] = fifo_full;
            prdata[15:0]           = 16'(fifo_count);
          end else begin
            ovf_d = 1'b0;
          end
        end
        reg_idx(CYCLES_OFFS): begin
          pslverr = acc_wr;
          prdata  = acc_rd ? 32'(cycles_q) : '0;
        end
        default: pslverr = 1'b1;
      endcase
    end
    // No increment on the edge done sets, so the frozen value is the run length.
    cycles_d = (done_q || done_d) ? cycles_q : cycles_q + CNT_W'(1);
    eoc_d    = done_q;
    irq_d    = ~fifo_empty;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      status_q  <= '0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      eoc_q     <= 1'b0;
      irq_q     <= 1'b0;
      cycles_q  <= '0;
    end else begin
      status_q  <= status_d;
      scratch_q <= scratch_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      eoc_q     <= eoc_d;
      irq_q     <= irq_d;
      cycles_q  <= cycles_d;
    end
  end

endmodule

// File: tb/tb_core_status_apb.sv
// Bench for core_status_apb: directed scenarios plus randomized traffic against a queue-based model.
module tb_core_status_apb;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [11:0] paddr  = '0;
  logic        psel   = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, eoc_o, char_irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  q_m[$];
  logic        ovf_m     = 1'b0;
  logic [31:0] scratch_m = '0;

  localparam logic [11:0] A_STATUS  = 12'h000;
  localparam logic [11:0] A_SCRATCH = 12'h004;
  localparam logic [11:0] A_PUSH    = 12'h008;
  localparam logic [11:0] A_POP     = 12'h00C;
  localparam logic [11:0] A_FSTAT   = 12'h010;
  localparam logic [11:0] A_CYCLES  = 12'h014;

  always #5 clk_in = ~clk_in;

  core_status_apb #(.APB_AW(12), .FIFO_DEPTH(16), .CNT_W(32)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .eoc_o      (eoc_o),
    .char_irq_o (char_irq_o)
  );

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic e);
    @(negedge clk_in);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk_in);
    penable = 1'b1;
    #1;
    r = prdata;
    e = pslverr;
    @(posedge clk_in);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  function automatic logic [31:0] fstat_exp();
    logic [15:0] c;
    c = 16'(q_m.size());
    return {ovf_m, 14'b0, (q_m.size() == 16), c};
  endfunction

  task automatic test_reset();
    logic [31:0] r, c1, c2;
    logic e;
    logic [11:0] addrs [4];
    addrs = '{A_STATUS, A_SCRATCH, A_FSTAT, A_POP};
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if (eoc_o !== 1'b0 || pready !== 1'b1 || char_irq_o !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0)
      $display("FAIL reset_outputs eoc=%b pready=%b irq=%b prdata=%h err=%b, need 0 1 0 0 0",
               eoc_o, pready, char_irq_o, prdata, pslverr);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, addrs[i], 32'h0, r, e);
      n_checks++;
      if (r !== 32'h0 || e !== 1'b0)
        $display("FAIL reset_read addr=%h got %h err=%b, need 0 err=0", addrs[i], r, e);
      else n_pass++;
    end
    apb(1'b0, A_CYCLES, 32'h0, c1, e);
    apb(1'b0, A_CYCLES, 32'h0, c2, e);
    n_checks++;
    if (c2 - c1 !== 32'd2 || c1 > 32'd20)
      $display("FAIL reset_cycles got c1=%0d c2=%0d, need small c1 and c2=c1+2", c1, c2);
    else n_pass++;
  endtask

  task automatic test_hi();
    logic [31:0] r;
    logic e;
    logic [7:0] ch [2];
    ch = '{8'h48, 8'h69};
    for (int i = 0; i < 2; i++) begin
      apb(1'b1, A_PUSH, {24'h0, ch[i]}, r, e);
      q_m.push_back(ch[i]);
      n_checks++;
      if (e !== 1'b0) $display("FAIL hi_push_err got %b need 0", e); else n_pass++;
    end
    apb(1'b0, A_FSTAT, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h0000_0002) $display("FAIL hi_fstat got %h need 00000002", r); else n_pass++;
    n_checks++;
    if (char_irq_o !== 1'b1) $display("FAIL hi_irq_set got %b need 1", char_irq_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      exp = (q_m.size() != 0) ? {1'b1, 23'b0, q_m.pop_front()} : 32'h0;
      apb(1'b0, A_POP, 32'h0, r, e);
      n_checks++;
      if (r !== exp || e !== 1'b0) $display("FAIL hi_pop%0d got %h err=%b need %h err=0", i, r, e, exp);
      else n_pass++;
    end
    n_checks++;
    if (char_irq_o !== 1'b0) $display("FAIL hi_irq_clear got %b need 0", char_irq_o); else n_pass++;
  endtask

  task automatic test_overflow_wrap();
    logic [31:0] r;
    logic e;
    int bad = 0;
    for (int i = 0; i <= 16; i++) begin
      apb(1'b1, A_PUSH, 32'(i), r, e);
      if (q_m.size() == 16) ovf_m = 1'b1; else q_m.push_back(8'(i));
      if (e !== (i == 16)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ovf_push_err %0d pushes had wrong pslverr, need 0", bad); else n_pass++;
    apb(1'b0, A_FSTAT, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h8001_0010) $display("FAIL ovf_fstat got %h need 80010010", r); else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      apb(1'b0, A_POP, 32'h0, r, e);
      if (r !== {1'b1, 23'b0, q_m.pop_front()}) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ovf_drain %0d pops wrong, need 0", bad); else n_pass++;
    apb(1'b1, A_FSTAT, 32'hFFFF_FFFF, r, e);
    ovf_m = 1'b0;
    apb(1'b0, A_FSTAT, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h0) $display("FAIL ovf_clear got %h need 00000000", r); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      apb(1'b1, A_PUSH, {24'h0, v}, r, e);
      apb(1'b0, A_POP, 32'h0, r, e);
      if (r !== {1'b1, 23'b0, v}) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wrap_pairs %0d pairs wrong, need 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r, d, exp;
    logic e, exp_e;
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 7);
      d  = $urandom;
      exp = 32'h0;
      exp_e = 1'b0;
      case (op)
        0: begin apb(1'b1, A_SCRATCH, d, r, e); scratch_m = d; end
        1: begin apb(1'b0, A_SCRATCH, d, r, e); exp = scratch_m; end
        2, 3: begin
          apb(1'b1, A_PUSH, d, r, e);
          if (q_m.size() == 16) begin ovf_m = 1'b1; exp_e = 1'b1; end
          else q_m.push_back(d[7:0]);
        end
        4, 7: begin
          apb(1'b0, A_POP, d, r, e);
          if (q_m.size() != 0) exp = {1'b1, 23'b0, q_m.pop_front()};
        end
        5: begin exp = fstat_exp(); apb(1'b0, A_FSTAT, d, r, e); end
        default: begin apb(1'b1, A_FSTAT, d, r, e); ovf_m = 1'b0; end
      endcase
      if (op == 0 || op == 2 || op == 3 || op == 6) r = 32'h0;
      n_checks++;
      if (r !== exp || e !== exp_e)
        $display("FAIL random op%0d step%0d got %h err=%b need %h err=%b", op, n, r, e, exp, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    logic e;
    logic [31:0] fs;
    fs = fstat_exp();
    apb(1'b0, 12'h018, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h0 || e !== 1'b1) $display("FAIL unmapped_rd got %h err=%b need 0 err=1", r, e); else n_pass++;
    apb(1'b1, 12'h01C, 32'hDEAD_BEEF, r, e);
    n_checks++;
    if (e !== 1'b1) $display("FAIL unmapped_wr err=%b need 1", e); else n_pass++;
    apb(1'b1, A_POP, 32'h0, r, e);
    n_checks++;
    if (e !== 1'b1) $display("FAIL pop_wr err=%b need 1", e); else n_pass++;
    apb(1'b1, A_CYCLES, 32'h0, r, e);
    n_checks++;
    if (e !== 1'b1) $display("FAIL cycles_wr err=%b need 1", e); else n_pass++;
    apb(1'b0, A_PUSH, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h0 || e !== 1'b1) $display("FAIL push_rd got %h err=%b need 0 err=1", r, e); else n_pass++;
    apb(1'b0, A_FSTAT, 32'h0, r, e);
    n_checks++;
    if (r !== fs) $display("FAIL err_no_side_effect fstat got %h need %h", r, fs); else n_pass++;
    apb(1'b1, 12'hF04, 32'h1234_5678, r, e);
    scratch_m = 32'h1234_5678;
    apb(1'b0, A_SCRATCH, 32'h0, r, e);
    n_checks++;
    if (r !== scratch_m) $display("FAIL alias_scratch got %h need %h", r, scratch_m); else n_pass++;
  endtask

  task automatic test_status();
    logic [31:0] r, c1, c2;
    logic e;
    apb(1'b1, A_STATUS, 32'h0000_0005, r, e);
    apb(1'b0, A_STATUS, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h5 || e !== 1'b0) $display("FAIL status_5 got %h err=%b need 00000005", r, e); else n_pass++;
    apb(1'b1, A_STATUS, 32'h8000_0000, r, e);
    n_checks++;
    if (eoc_o !== 1'b0) $display("FAIL eoc_early got %b need 0", eoc_o); else n_pass++;
    @(posedge clk_in); #1;
    n_checks++;
    if (eoc_o !== 1'b1) $display("FAIL eoc_rise got %b need 1", eoc_o); else n_pass++;
    apb(1'b0, A_STATUS, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h8000_0000) $display("FAIL status_done got %h need 80000000", r); else n_pass++;
    apb(1'b0, A_CYCLES, 32'h0, c1, e);
    repeat (50) @(posedge clk_in);
    apb(1'b0, A_CYCLES, 32'h0, c2, e);
    n_checks++;
    if (c2 !== c1 || c1 == 32'h0) $display("FAIL cycles_frozen got %0d then %0d, need equal nonzero", c1, c2);
    else n_pass++;
    apb(1'b1, A_STATUS, 32'h8000_0001, r, e);
    n_checks++;
    if (e !== 1'b1) $display("FAIL status_locked_err got %b need 1", e); else n_pass++;
    apb(1'b0, A_STATUS, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h8000_0000) $display("FAIL status_locked_val got %h need 80000000", r); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, c1, c2;
    logic e;
    while (q_m.size() != 0) begin
      apb(1'b0, A_POP, 32'h0, r, e);
      void'(q_m.pop_front());
    end
    apb(1'b1, A_FSTAT, 32'h0, r, e);
    ovf_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apb(1'b1, A_PUSH, 32'h30 + 32'(i), r, e);
      q_m.push_back(8'h30 + 8'(i));
    end
    @(negedge clk_in);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_FSTAT;
    @(negedge clk_in);
    penable = 1'b1;
    #1;
    n_checks++;
    if (prdata !== 32'h5 || eoc_o !== 1'b1 || char_irq_o !== 1'b1)
      $display("FAIL pre_reset got fstat=%h eoc=%b irq=%b need 00000005 1 1", prdata, eoc_o, char_irq_o);
    else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (prdata !== 32'h0 || eoc_o !== 1'b0 || char_irq_o !== 1'b0)
      $display("FAIL async_reset got fstat=%h eoc=%b irq=%b need 0 0 0", prdata, eoc_o, char_irq_o);
    else n_pass++;
    psel = 1'b0; penable = 1'b0;
    q_m.delete();
    scratch_m = '0;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    apb(1'b0, A_STATUS, 32'h0, r, e);
    n_checks++;
    if (r !== 32'h0) $display("FAIL post_reset_status got %h need 0", r); else n_pass++;
    apb(1'b0, A_CYCLES, 32'h0, c1, e);
    apb(1'b0, A_CYCLES, 32'h0, c2, e);
    n_checks++;
    if (c1 > 32'd10 || c2 - c1 !== 32'd2)
      $display("FAIL post_reset_cycles got %0d then %0d, need small then +2", c1, c2);
    else n_pass++;
    apb(1'b1, A_STATUS, 32'h0000_0007, r, e);
    n_checks++;
    if (e !== 1'b0) $display("FAIL post_reset_status_wr err=%b need 0", e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hi();
    test_overflow_wrap();
    test_random();
    test_errors();
    test_status();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
